sdram_arbiter: RTL and testbench

Two-port request arbiter and refresh scheduler sitting directly upstream of the SDRAM controller. It multiplexes a video/DMA port (A) and a CPU port (B) onto the controller's single cs/we/addr/ds/din interface in fixed 8-cycle slots, inserts periodic auto-refresh slots, and returns read data with a one-cycle acknowledge per port.

---
 rtl/sdram_arbiter.sv | 222 ++++++++++++++++++++++
 tb/tb_sdram_arbiter.sv | 376 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sdram_arbiter.sv
// -----------------------------------------------------------------------------
// sdram_arbiter
//
// Two-port request arbiter and refresh scheduler in front of the SDRAM
// controller. Port A (video/DMA) and port B (CPU) share the controller's
// single cs/we/addr/ds/din interface in fixed 8-cycle slots (s = 0..7).
// Periodic auto-refresh slots are inserted from a free-running timer.
//
// Grant priority at slot start: pending refresh > port A > port B.
// The grant is made while idle, or in the s=7 cycle of the current slot.
// A fully loaded bus therefore runs one slot every 8 cycles.
//
// Slot timeline (registered outputs):
//   s=0..4  ram_cs high (rises on entry to s=0, falls on entry to s=5)
//   s=5     ram_dout captured into the owner's dout on the edge leaving s=5
//   s=6     owner's ack high for one cycle
//   s=7     next grant decided
//
// Ports:
//   clk, reset_n            clock, synchronous active-low reset
//   ram_ready               controller initialised; gates slot starts only
//   ram_cs, ram_refresh     controller strobe / refresh-slot marker
//   ram_we, ram_addr,       request fields of the slot owner, held for the
//   ram_ds, ram_din         whole slot
//   ram_dout                read data from the controller
//   {a,b}_req/we/addr/ds/din  port requests (level, held until ack)
//   {a,b}_ack               one-cycle completion pulse at s=6
//   {a,b}_dout              read data, valid from the ack cycle, then held
// -----------------------------------------------------------------------------
module sdram_arbiter #(
  parameter int unsigned REFRESH_CYCLES = 250
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        ram_ready,
  output logic        ram_cs,
  output logic        ram_refresh,
  output logic        ram_we,
  output logic [21:0] ram_addr,
  output logic [1:0]  ram_ds,
  output logic [15:0] ram_din,
  input  logic [15:0] ram_dout,
  input  logic        a_req,
  input  logic        a_we,
  input  logic [21:0] a_addr,
  input  logic [1:0]  a_ds,
  input  logic [15:0] a_din,
  output logic        a_ack,
  output logic [15:0] a_dout,
  input  logic        b_req,
  input  logic        b_we,
  input  logic [21:0] b_addr,
  input  logic [1:0]  b_ds,
  input  logic [15:0] b_din,
  output logic        b_ack,
  output logic [15:0] b_dout
);

  typedef enum logic {
    ST_IDLE,
    ST_SLOT
  } state_t;

  typedef enum logic [1:0] {
    SRC_NONE,
    SRC_REF,
    SRC_A,
    SRC_B
  } src_t;

  localparam logic [15:0] REF_RELOAD = 16'(REFRESH_CYCLES - 1);

  state_t      state, state_n;
  logic [2:0]  s, s_n;
  src_t        sel;
  src_t        owner;
  logic        slot_end;
  logic        start;
  logic        tick;
  logic        ref_grant;
  logic [15:0] ref_cnt;
  logic [1:0]  pending;

  // ---------------------------------------------------------------------------
  // Grant selection and slot sequencing
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every output of this block is given a default before any branch,
    // so no path can leave one unassigned and infer a latch.
    sel      = SRC_NONE;
    state_n  = state;
    s_n      = s;
    start    = 1'b0;
    slot_end = (state == ST_SLOT) && (s == 3'd7);

    if (pending != 2'd0)
      sel = SRC_REF;
    else if (a_req)
      sel = SRC_A;
    else if (b_req)
      sel = SRC_B;

    // Deciding in s=7 lets back-to-back slots run without an idle gap.
    if (ram_ready && (state == ST_IDLE || slot_end) && sel != SRC_NONE)
      start = 1'b1;

    if (start) begin
      state_n = ST_SLOT;
      s_n     = 3'd0;
    end else if (slot_end) begin
      state_n = ST_IDLE;
      s_n     = 3'd0;
    end else if (state == ST_SLOT) begin
      s_n = s + 3'd1;
    end
  end

  assign ref_grant = start && (sel == SRC_REF);
  assign tick      = (ref_cnt == 16'd0);

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (!reset_n) begin
      state <= ST_IDLE;
      s     <= 3'd0;
    end else begin
      state <= state_n;
      s     <= s_n;
    end
  end

  // ---------------------------------------------------------------------------
  // Controller-side request registers, ack pulses and read capture
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      owner       <= SRC_NONE;
      ram_cs      <= 1'b0;
      ram_refresh <= 1'b0;
      ram_we      <= 1'b0;
      ram_addr    <= '0;
      ram_ds      <= '0;
      ram_din     <= '0;
      a_ack       <= 1'b0;
      b_ack       <= 1'b0;
      a_dout      <= '0;
      b_dout      <= '0;
    end else begin
      a_ack <= 1'b0;
      b_ack <= 1'b0;

      if (start) begin
        owner       <= sel;
        ram_cs      <= 1'b1;
        ram_refresh <= (sel == SRC_REF);
        case (sel)
          SRC_REF: begin
            // Address and write data are don't-care; keep them unchanged.
            ram_we <= 1'b0;
            ram_ds <= 2'b00;
          end
          SRC_A: begin
            ram_we   <= a_we;
            ram_addr <= a_addr;
            ram_ds   <= a_ds;
            ram_din  <= a_din;
          end
          SRC_B: begin
            ram_we   <= b_we;
            ram_addr <= b_addr;
            ram_ds   <= b_ds;
            ram_din  <= b_din;
          end
          default: ;
        endcase
      end else begin
        // Dropping cs for s=5..7 guarantees a fresh rising edge next slot.
        if (state == ST_SLOT && s == 3'd4)
          ram_cs <= 1'b0;
        if (slot_end)
          ram_refresh <= 1'b0;
      end

      // Controller has data on its bus during s=5; capture on leaving it.
      if (state == ST_SLOT && s == 3'd5) begin
        case (owner)
          SRC_A: begin
            a_ack <= 1'b1;
            if (!ram_we)
              a_dout <= ram_dout;
          end
          SRC_B: begin
            b_ack <= 1'b1;
            if (!ram_we)
              b_dout <= ram_dout;
          end
          default: ;
        endcase
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Refresh timer and pending-refresh count (saturates at 3)
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      ref_cnt <= REF_RELOAD;
      pending <= 2'd0;
    end else begin
      ref_cnt <= tick ? REF_RELOAD : ref_cnt - 16'd1;
      // A tick and a refresh grant in the same cycle cancel out.
      case ({tick, ref_grant})
        2'b10:   if (pending != 2'd3) pending <= pending + 2'd1;
        2'b01:   pending <= pending - 2'd1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sdram_arbiter.sv
// -----------------------------------------------------------------------------
// tb_sdram_arbiter
//
// Self-checking bench for sdram_arbiter. Two instances share clock, reset,
// ready and port data: dut (REFRESH_CYCLES=250) exercises port traffic, with a
// reset before each scenario so no refresh slot lands inside it; dut_r
// (REFRESH_CYCLES=16) exercises refresh scheduling with its own request lines.
// A small controller model returns model_rdata on ram_dout only during s=5 of
// a dut slot, so a capture on the wrong edge reads 16'h0BAD.
// Inputs are driven 1 time unit after the rising edge; outputs are sampled
// at the same point, i.e. they reflect the registers updated by that edge.
// -----------------------------------------------------------------------------
module tb_sdram_arbiter;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        ram_ready;
  logic [15:0] ram_dout;
  logic        a_req, a_we, b_req, b_we;
  logic [21:0] a_addr, b_addr;
  logic [1:0]  a_ds, b_ds;
  logic [15:0] a_din, b_din;

  logic        ram_cs, ram_refresh, ram_we;
  logic [21:0] ram_addr;
  logic [1:0]  ram_ds;
  logic [15:0] ram_din;
  logic        a_ack, b_ack;
  logic [15:0] a_dout, b_dout;

  logic        ra_req, rb_req;
  logic        r_ram_cs, r_ram_refresh, r_ram_we;
  logic [21:0] r_ram_addr;
  logic [1:0]  r_ram_ds;
  logic [15:0] r_ram_din;
  logic        r_a_ack, r_b_ack;
  logic [15:0] r_a_dout, r_b_dout;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  sdram_arbiter #(.REFRESH_CYCLES(250)) dut (
    .clk(clk), .reset_n(reset_n), .ram_ready(ram_ready),
    .ram_cs(ram_cs), .ram_refresh(ram_refresh), .ram_we(ram_we),
    .ram_addr(ram_addr), .ram_ds(ram_ds), .ram_din(ram_din), .ram_dout(ram_dout),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_ds(a_ds), .a_din(a_din),
    .a_ack(a_ack), .a_dout(a_dout),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_ds(b_ds), .b_din(b_din),
    .b_ack(b_ack), .b_dout(b_dout)
  );

  sdram_arbiter #(.REFRESH_CYCLES(16)) dut_r (
    .clk(clk), .reset_n(reset_n), .ram_ready(ram_ready),
    .ram_cs(r_ram_cs), .ram_refresh(r_ram_refresh), .ram_we(r_ram_we),
    .ram_addr(r_ram_addr), .ram_ds(r_ram_ds), .ram_din(r_ram_din), .ram_dout(ram_dout),
    .a_req(ra_req), .a_we(a_we), .a_addr(a_addr), .a_ds(a_ds), .a_din(a_din),
    .a_ack(r_a_ack), .a_dout(r_a_dout),
    .b_req(rb_req), .b_we(b_we), .b_addr(b_addr), .b_ds(b_ds), .b_din(b_din),
    .b_ack(r_b_ack), .b_dout(r_b_dout)
  );

  // Controller model: counts cycles since the sampled cs rise (1 = s1 ...).
  logic        cs_q;
  logic [2:0]  ctr;
  logic [15:0] model_rdata;

  always @(posedge clk) begin
    if (!reset_n) begin
      cs_q <= 1'b0;
      ctr  <= 3'd0;
    end else begin
      cs_q <= ram_cs;
      if (ram_cs && !cs_q)
        ctr <= 3'd1;
      else if (ctr != 3'd0)
        ctr <= ctr + 3'd1;
    end
  end

  assign ram_dout = (ctr == 3'd5) ? model_rdata : 16'h0BAD;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp)
      n_pass++;
    else
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic r_prev;

  task automatic do_reset();
    a_req   = 1'b0;
    b_req   = 1'b0;
    reset_n = 1'b0;
    step();
    step();
    reset_n = 1'b1;
    r_prev  = 1'b0;
  endtask

  // ---------------------------------------------------------------------------
  // Single-transaction vectors on an otherwise idle bus
  // ---------------------------------------------------------------------------
  typedef struct {
    logic        port_b;
    logic        we;
    logic [21:0] addr;
    logic [1:0]  ds;
    logic [15:0] din;
    logic [15:0] rdata;
    logic [15:0] exp_a_dout;
    logic [15:0] exp_b_dout;
  } vec_t;

  vec_t vecs[6];

  task automatic run_vec(input int k, input vec_t v);
    int          ack_idx = -1;
    int          cs_hi = 0;
    logic        stable = 1'b1;
    logic        refr = 1'b0;
    logic        other_ack = 1'b0;
    logic [15:0] dout_at_ack = 16'hDEAD;
    model_rdata = v.rdata;
    if (v.port_b) begin
      b_req = 1'b1; b_we = v.we; b_addr = v.addr; b_ds = v.ds; b_din = v.din;
    end else begin
      a_req = 1'b1; a_we = v.we; a_addr = v.addr; a_ds = v.ds; a_din = v.din;
    end
    for (int i = 1; i <= 8; i++) begin
      step();
      if (ram_cs) cs_hi++;
      if (ram_refresh) refr = 1'b1;
      if (ram_we !== v.we || ram_addr !== v.addr || ram_ds !== v.ds || ram_din !== v.din)
        stable = 1'b0;
      if (v.port_b ? b_ack : a_ack) begin
        if (ack_idx < 0) begin
          ack_idx     = i;
          dout_at_ack = v.port_b ? b_dout : a_dout;
        end
        if (v.port_b) b_req = 1'b0; else a_req = 1'b0;
      end
      if (v.port_b ? a_ack : b_ack) other_ack = 1'b1;
    end
    check($sformatf("vec%0d_ack_cycle", k), 64'(ack_idx), 64'(7));
    check($sformatf("vec%0d_cs_cycles", k), 64'(cs_hi), 64'(5));
    check($sformatf("vec%0d_bus_stable", k), 64'({stable, refr}), 64'(2'b10));
    check($sformatf("vec%0d_other_ack", k), 64'(other_ack), 64'(0));
    check($sformatf("vec%0d_dout_at_ack", k), 64'(dout_at_ack),
          64'(v.port_b ? v.exp_b_dout : v.exp_a_dout));
    check($sformatf("vec%0d_other_dout", k), 64'(v.port_b ? a_dout : b_dout),
          64'(v.port_b ? v.exp_a_dout : v.exp_b_dout));
  endtask

  // ---------------------------------------------------------------------------
  // dut_r slot monitor: records cs rises (cycle index, refresh flag)
  // ---------------------------------------------------------------------------
  int   rec_idx[16];
  logic rec_ref[16];
  int   n_rec;
  int   r_ref_hi;
  int   r_bad_ref;

  task automatic monitor_r(input int from_i, input int to_i);
    for (int i = from_i; i <= to_i; i++) begin
      step();
      if (r_ram_refresh) r_ref_hi++;
      if (r_ram_cs && !r_prev) begin
        if (n_rec < 16) begin
          rec_idx[n_rec] = i;
          rec_ref[n_rec] = r_ram_refresh;
        end
        n_rec++;
        if (r_ram_refresh && (r_ram_we || r_ram_ds != 2'b00)) r_bad_ref++;
      end
      r_prev = r_ram_cs;
    end
  endtask

  task automatic clear_rec();
    n_rec     = 0;
    r_ref_hi  = 0;
    r_bad_ref = 0;
  endtask

  // ---------------------------------------------------------------------------
  // Main sequence
  // ---------------------------------------------------------------------------
  initial begin
    int   ack_idx, ack2_idx, cnt, rise1, rise2, gap_low;
    logic prev_cs;
    logic [21:0] addr1, addr2;
    int   exp_idx[10];
    logic exp_ref[10];

    vecs[0] = '{1'b1, 1'b0, 22'h012345, 2'b11, 16'h0000, 16'hBEEF, 16'h0000, 16'hBEEF};
    vecs[1] = '{1'b0, 1'b1, 22'h3FFFFF, 2'b10, 16'hA55A, 16'h4444, 16'h0000, 16'hBEEF};
    vecs[2] = '{1'b0, 1'b0, 22'h000000, 2'b01, 16'h1111, 16'h1234, 16'h1234, 16'hBEEF};
    vecs[3] = '{1'b1, 1'b1, 22'h2AAAAA, 2'b11, 16'h5A5A, 16'h6666, 16'h1234, 16'hBEEF};
    vecs[4] = '{1'b0, 1'b1, 22'h155555, 2'b01, 16'h00FF, 16'h7070, 16'h1234, 16'hBEEF};
    vecs[5] = '{1'b1, 1'b0, 22'h000001, 2'b10, 16'h2222, 16'h8001, 16'h1234, 16'h8001};

    reset_n = 1'b0; ram_ready = 1'b1; model_rdata = 16'h0000;
    a_req = 1'b0; a_we = 1'b0; a_addr = '0; a_ds = '0; a_din = '0;
    b_req = 1'b0; b_we = 1'b0; b_addr = '0; b_ds = '0; b_din = '0;
    ra_req = 1'b0; rb_req = 1'b0; r_prev = 1'b0;

    // Reset state
    do_reset();
    check("reset_ram_bus", 64'({ram_cs, ram_refresh, ram_we, ram_ds, ram_addr, ram_din}), 64'(0));
    check("reset_acks", 64'({a_ack, b_ack}), 64'(0));
    check("reset_douts", 64'({a_dout, b_dout}), 64'(0));

    // Table of single transactions
    for (int k = 0; k < 6; k++) run_vec(k, vecs[k]);

    // Simultaneous A and B requests: A first, B exactly 8 cycles later
    do_reset();
    model_rdata = 16'hC0DE;
    a_we = 1'b0; a_addr = 22'h000100; a_ds = 2'b11;
    b_we = 1'b0; b_addr = 22'h000200; b_ds = 2'b11;
    a_req = 1'b1; b_req = 1'b1;
    ack_idx = -1; ack2_idx = -1; rise1 = -1; rise2 = -1; gap_low = 0;
    addr1 = '0; addr2 = '0; prev_cs = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      step();
      if (ram_cs && !prev_cs) begin
        if (rise1 < 0) begin rise1 = i; addr1 = ram_addr; end
        else if (rise2 < 0) begin rise2 = i; addr2 = ram_addr; end
      end
      if (rise1 >= 0 && rise2 < 0 && !ram_cs) gap_low++;
      prev_cs = ram_cs;
      if (a_ack) begin if (ack_idx < 0) ack_idx = i; a_req = 1'b0; end
      if (b_ack) begin if (ack2_idx < 0) ack2_idx = i; b_req = 1'b0; end
    end
    check("sim_rise_a", 64'(rise1), 64'(1));
    check("sim_rise_b", 64'(rise2), 64'(9));
    check("sim_cs_gap", 64'(gap_low), 64'(3));
    check("sim_addr_a", 64'(addr1), 64'(22'h000100));
    check("sim_addr_b", 64'(addr2), 64'(22'h000200));
    check("sim_ack_a", 64'(ack_idx), 64'(7));
    check("sim_ack_b", 64'(ack2_idx), 64'(15));
    check("sim_douts", 64'({a_dout, b_dout}), 64'({16'hC0DE, 16'hC0DE}));

    // Ready gating, and ready falling mid-slot
    do_reset();
    ram_ready = 1'b0;
    a_we = 1'b1; a_addr = 22'h0ABCDE; a_ds = 2'b11; a_din = 16'h1357; a_req = 1'b1;
    cnt = 0;
    for (int i = 1; i <= 10; i++) begin
      step();
      if (ram_cs) cnt++;
    end
    check("ready_low_no_cs", 64'(cnt), 64'(0));
    ram_ready = 1'b1;
    step();
    check("ready_grant", 64'({ram_cs, ram_we, ram_addr}), 64'({2'b11, 22'h0ABCDE}));
    b_we = 1'b0; b_addr = 22'h1F0F0F; b_ds = 2'b11;
    ack_idx = -1;
    for (int j = 1; j <= 8; j++) begin
      step();
      if (j == 2) ram_ready = 1'b0;
      if (a_ack) begin
        if (ack_idx < 0) ack_idx = j;
        a_req = 1'b0;
        b_req = 1'b1;
      end
    end
    check("ready_drop_ack", 64'(ack_idx), 64'(6));
    cnt = 0;
    for (int i = 1; i <= 8; i++) begin
      step();
      if (ram_cs) cnt++;
    end
    check("ready_low_hold_b", 64'(cnt), 64'(0));
    ram_ready = 1'b1;
    model_rdata = 16'h2468;
    step();
    check("ready_grant_b", 64'({ram_cs, ram_addr}), 64'({1'b1, 22'h1F0F0F}));
    ack_idx = -1;
    for (int j = 1; j <= 8; j++) begin
      step();
      if (b_ack) begin if (ack_idx < 0) ack_idx = j; b_req = 1'b0; end
    end
    check("ready_b_ack", 64'(ack_idx), 64'(6));
    check("ready_b_dout", 64'(b_dout), 64'(16'h2468));

    // Reset during s=3 of a B read
    do_reset();
    model_rdata = 16'h7777;
    b_we = 1'b0; b_addr = 22'h000042; b_ds = 2'b11; b_req = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      step();
      if (b_ack) b_req = 1'b0;
    end
    check("rst_pre_dout", 64'(b_dout), 64'(16'h7777));
    model_rdata = 16'h9999;
    b_req = 1'b1;
    for (int i = 1; i <= 4; i++) step();
    check("rst_at_s3_cs", 64'(ram_cs), 64'(1));
    reset_n = 1'b0;
    step();
    check("rst_mid_outputs", 64'({ram_cs, b_ack, b_dout}), 64'(0));
    reset_n = 1'b1;
    ack_idx = -1;
    for (int i = 1; i <= 10; i++) begin
      step();
      if (b_ack) begin if (ack_idx < 0) ack_idx = i; b_req = 1'b0; end
    end
    check("rst_resume_ack", 64'(ack_idx), 64'(7));
    check("rst_resume_dout", 64'(b_dout), 64'(16'h9999));

    // Refresh, ports idle: slots at 17, 33, 49 after reset
    do_reset();
    clear_rec();
    monitor_r(1, 60);
    exp_idx[0] = 17; exp_idx[1] = 33; exp_idx[2] = 49;
    check("ref_idle_nslots", 64'(n_rec), 64'(3));
    for (int k = 0; k < 3; k++) begin
      check($sformatf("ref_idle_slot%0d", k), 64'({rec_idx[k], rec_ref[k]}),
            64'({exp_idx[k], 1'b1}));
    end
    check("ref_idle_hi_cycles", 64'(r_ref_hi), 64'(24));
    check("ref_idle_we_ds", 64'(r_bad_ref), 64'(0));

    // Refresh pre-empting a saturating port A
    ra_req = 1'b1;
    do_reset();
    clear_rec();
    monitor_r(1, 56);
    exp_idx = '{1, 9, 17, 25, 33, 41, 49, 0, 0, 0};
    exp_ref = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    check("ref_busy_nslots", 64'(n_rec), 64'(7));
    for (int k = 0; k < 7; k++) begin
      check($sformatf("ref_busy_slot%0d", k), 64'({rec_idx[k], rec_ref[k]}),
            64'({exp_idx[k], exp_ref[k]}));
    end

    // Pending saturates at 3 while ready is low for 100 cycles
    ram_ready = 1'b0;
    do_reset();
    clear_rec();
    monitor_r(1, 100);
    check("ref_sat_no_cs", 64'(n_rec), 64'(0));
    ram_ready = 1'b1;
    clear_rec();
    monitor_r(101, 180);
    exp_idx = '{101, 109, 117, 125, 133, 141, 149, 157, 165, 173};
    exp_ref = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    check("ref_sat_nslots", 64'(n_rec), 64'(10));
    for (int k = 0; k < 10; k++) begin
      check($sformatf("ref_sat_slot%0d", k), 64'({rec_idx[k], rec_ref[k]}),
            64'({exp_idx[k], exp_ref[k]}));
    end
    check("ref_sat_we_ds", 64'(r_bad_ref), 64'(0));
    ra_req = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
